// File: rtl/sqrt_iter.sv
// Iterative restoring integer square root: one root bit per clock.
// Result registers hold until the next completion; go/busy/done handshake.
module sqrt_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic [WIDTH-1:0]   a,
    output logic               busy,
    output logic               done,
    output logic [WIDTH/2-1:0] root_reg,
    output logic [WIDTH/2:0]   rem_reg
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("sqrt_iter: WIDTH must be even and >= 4");
    end

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t         state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [N-1:0]   root_q;
    logic [N+1:0]   rem_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;
    logic [N-1:0]   root_reg_q;
    logic [N:0]     rem_reg_q;

    logic [N+1:0]   rem_t;
    logic [N+1:0]   trial;
    logic           ge;
    logic [N+1:0]   rem_d;
    logic [N-1:0]   root_d;

    // Remainder never exceeds 2*root, so N+2 bits hold every intermediate.
    always_comb begin
        rem_t  = (rem_q << 2) | {{N{1'b0}}, a_sh_q[WIDTH-1 -: 2]};
        trial  = {root_q, 2'b01};
        ge     = (rem_t >= trial);
        rem_d  = ge ? (rem_t - trial) : rem_t;
        root_d = {root_q[N-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            root_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            root_reg_q <= '0;
            rem_reg_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (go) begin
                        a_sh_q  <= a;
                        root_q  <= '0;
                        rem_q   <= '0;
                        cnt_q   <= CW'(N - 1);
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    a_sh_q <= a_sh_q << 2;
                    root_q <= root_d;
                    rem_q  <= rem_d;
                    if (cnt_q == '0) begin
                        root_reg_q <= root_d;
                        rem_reg_q  <= rem_d[N:0];
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign root_reg = root_reg_q;
    assign rem_reg  = rem_reg_q;

endmodule

// File: tb/tb_sqrt_iter.sv
// Scoreboard bench for sqrt_iter at WIDTH=16 (directed + random) and WIDTH=8 (exhaustive).
module tb_sqrt_iter;
    localparam int N16 = 8;
    localparam int N8  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        go16 = 1'b0;
    logic [15:0] a16 = '0;
    logic        busy16, done16;
    logic [7:0]  root16;
    logic [8:0]  rem16;

    logic        go8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic        busy8, done8;
    logic [3:0]  root8;
    logic [4:0]  rem8;

    sqrt_iter #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .go(go16), .a(a16),
        .busy(busy16), .done(done16), .root_reg(root16), .rem_reg(rem16)
    );

    sqrt_iter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .go(go8), .a(a8),
        .busy(busy8), .done(done8), .root_reg(root8), .rem_reg(rem8)
    );

    typedef struct {
        int root;
        int rem;
        int at;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t q16[$];
    exp_t q8[$];
    exp_t e16, e8;
    int last16 = -1000;
    int last8  = -1000;
    int h_root16 = 0, h_rem16 = 0;
    int h_root8  = 0, h_rem8  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    // Reference: largest r with r*r <= a, found by plain search.
    function automatic exp_t model(input int av, input int acc, input int n);
        exp_t r;
        int s = 0;
        while ((s + 1) * (s + 1) <= av) s++;
        r.root = s;
        r.rem  = av - s * s;
        r.at   = acc + n;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Acceptance model: a new go is taken once N+1 edges have passed since the last one.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q16.delete();
            q8.delete();
            last16 = -1000;
            last8  = -1000;
            h_root16 = 0; h_rem16 = 0;
            h_root8  = 0; h_rem8  = 0;
        end else begin
            if (go16 && (cyc + 1 >= last16 + N16 + 1)) begin
                last16 = cyc + 1;
                q16.push_back(model(int'(a16), cyc + 1, N16));
            end
            if (go8 && (cyc + 1 >= last8 + N8 + 1)) begin
                last8 = cyc + 1;
                q8.push_back(model(int'(a8), cyc + 1, N8));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy16", busy16, (cyc >= last16 && cyc < last16 + N16));
            if (done16) begin
                if (q16.size() == 0) fail("spurious_done16");
                else begin
                    e16 = q16.pop_front();
                    chk("root16", root16, e16.root);
                    chk("rem16", rem16, e16.rem);
                    chk("latency16", cyc, e16.at);
                    h_root16 = e16.root;
                    h_rem16  = e16.rem;
                end
            end else if (q16.size() != 0 && cyc >= q16[0].at) begin
                fail("missing_done16");
                void'(q16.pop_front());
            end
            chk("hold_root16", root16, h_root16);
            chk("hold_rem16", rem16, h_rem16);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy8", busy8, (cyc >= last8 && cyc < last8 + N8));
            if (done8) begin
                if (q8.size() == 0) fail("spurious_done8");
                else begin
                    e8 = q8.pop_front();
                    chk("root8", root8, e8.root);
                    chk("rem8", rem8, e8.rem);
                    chk("latency8", cyc, e8.at);
                    h_root8 = e8.root;
                    h_rem8  = e8.rem;
                end
            end else if (q8.size() != 0 && cyc >= q8[0].at) begin
                fail("missing_done8");
                void'(q8.pop_front());
            end
            chk("hold_root8", root8, h_root8);
            chk("hold_rem8", rem8, h_rem8);
        end
    end

    task automatic drain16();
        for (int i = 0; i < 40 && q16.size() != 0; i++) @(negedge clk);
        chk("drain16", q16.size(), 0);
    endtask

    task automatic drain8();
        for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
        chk("drain8", q8.size(), 0);
    endtask

    task automatic run16(input int v);
        @(negedge clk);
        go16 = 1'b1;
        a16  = v[15:0];
        @(negedge clk);
        go16 = 1'b0;
        drain16();
    endtask

    task automatic run8(input int v);
        @(negedge clk);
        go8 = 1'b1;
        a8  = v[7:0];
        @(negedge clk);
        go8 = 1'b0;
        drain8();
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy16", busy16, 0);
        chk("rst_done16", done16, 0);
        chk("rst_root16", root16, 0);
        chk("rst_rem16", rem16, 0);
        chk("rst_busy8", busy8, 0);
        rst_n = 1'b1;

        run16(0);
        run16(65535);
        chk("max_root16", root16, 255);
        chk("max_rem16", rem16, 510);
        run16(144);
        run16(143);

        // Back-to-back: go stays high, new operand at the restart edge.
        @(negedge clk);
        go16 = 1'b1;
        a16  = 16'd100;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done16) break;
        end
        if (!done16) fail("b2b_first_done_timeout");
        a16 = 16'd99;
        @(negedge clk);
        go16 = 1'b0;
        drain16();
        chk("b2b_root16", root16, 9);
        chk("b2b_rem16", rem16, 18);

        // go during CALC must be ignored.
        @(negedge clk);
        go16 = 1'b1;
        a16  = 16'd10000;
        @(negedge clk);
        go16 = 1'b0;
        repeat (2) @(negedge clk);
        go16 = 1'b1;
        a16  = 16'd4;
        @(negedge clk);
        go16 = 1'b0;
        drain16();
        chk("ign_root16", root16, 100);
        repeat (12) @(negedge clk);

        // Reset mid-CALC after a prior result.
        run16(144);
        @(negedge clk);
        go16 = 1'b1;
        a16  = 16'd5000;
        @(negedge clk);
        go16 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy16", busy16, 0);
        chk("mid_rst_done16", done16, 0);
        chk("mid_rst_root16", root16, 0);
        chk("mid_rst_rem16", rem16, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run16(81);
        chk("post_rst_root16", root16, 9);

        for (int i = 0; i < 40; i++) begin
            run16(int'($urandom_range(0, 65535)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        for (int v = 0; v < 256; v++) run8(v);
        chk("max_root8", root8, 15);
        chk("max_rem8", rem8, 30);

        repeat (5) @(negedge clk);
        chk("final_q16", q16.size(), 0);
        chk("final_q8", q8.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
